// File: rtl/adc_avg_fifo.sv
`default_nettype none
// ============================================================================
// Module      : adc_avg_fifo
// Description : Averages 2^AVG_LOG2 ADC samples into a truncated mean and
//               queues each mean in a DEPTH-entry show-ahead FIFO.
//               Optional macro ADC_AVG_DROPCNT_EN adds a saturating drop_count.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_avg_fifo #(
    parameter int AVG_LOG2 = 2,
    parameter int DEPTH    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [11:0]              sample_in,
    input  logic                     sample_valid,
    input  logic                     flush,
    input  logic                     rd_en,
    output logic [11:0]              rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
`ifdef ADC_AVG_DROPCNT_EN
    ,
    output logic [15:0]              drop_count
`endif
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;
    localparam logic [c_LVL_W-1:0] c_FULL_LVL = c_LVL_W'(DEPTH);

    logic        w_offer;
    logic [11:0] w_mean;

    if (AVG_LOG2 == 0) begin : g_pass
        assign w_offer = sample_valid & ~flush & ~reset;
        assign w_mean  = sample_in;
    end else begin : g_avg
        localparam int c_CNT_W = AVG_LOG2;
        logic [11+AVG_LOG2:0] r_acc;
        logic [11+AVG_LOG2:0] w_sum;
        logic [c_CNT_W-1:0]   r_cnt;
        logic                 w_last;

        // Accumulator is 12+AVG_LOG2 bits wide, so the full sum always fits.
        assign w_sum   = r_acc + {{AVG_LOG2{1'b0}}, sample_in};
        assign w_last  = &r_cnt;
        assign w_offer = sample_valid & ~flush & ~reset & w_last;
        assign w_mean  = w_sum[11+AVG_LOG2:AVG_LOG2];

        always_ff @(posedge clk) begin
            if (reset || flush) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (sample_valid) begin
                if (w_last) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end
        end
    end

    logic [11:0]        r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] w_rd_ptr_nxt;
    logic [c_LVL_W-1:0] r_level;
    logic [11:0]        r_rd_data;
    logic               r_overflow;
    logic               w_pop_ok;
    logic               w_push_ok;
    logic               w_drop;

    assign w_pop_ok     = rd_en & ~flush & ~reset & (r_level != '0);
    assign w_push_ok    = w_offer & ((r_level != c_FULL_LVL) | w_pop_ok);
    assign w_drop       = w_offer & ~w_push_ok;
    assign w_rd_ptr_nxt = r_rd_ptr + c_PTR_W'(1);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_mean;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_rd_data  <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= w_rd_ptr_nxt;
            if (w_drop)    r_overflow <= 1'b1;

            // rd_data is registered, so it is loaded with the entry that
            // becomes the head after this edge; it holds when nothing replaces it.
            case ({w_push_ok, w_pop_ok})
                2'b10: begin
                    r_level <= r_level + c_LVL_W'(1);
                    if (r_level == '0) r_rd_data <= w_mean;
                end
                2'b01: begin
                    r_level <= r_level - c_LVL_W'(1);
                    if (r_level != c_LVL_W'(1)) r_rd_data <= r_mem[w_rd_ptr_nxt];
                end
                2'b11: begin
                    if (r_level == c_LVL_W'(1)) r_rd_data <= w_mean;
                    else                        r_rd_data <= r_mem[w_rd_ptr_nxt];
                end
                default: ;
            endcase
        end
    end

`ifdef ADC_AVG_DROPCNT_EN
    logic [15:0] r_drop_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_count <= '0;
        end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign drop_count = r_drop_count;
`endif

    assign rd_data  = r_rd_data;
    assign level    = r_level;
    assign empty    = (r_level == '0);
    assign full     = (r_level == c_FULL_LVL);
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_adc_avg_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_avg_fifo
// Description : Scoreboard bench for adc_avg_fifo (AVG_LOG2=2, DEPTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_avg_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        flush = 1'b0;
    logic        rd_en = 1'b0;
    logic [11:0] rd_data;
    logic        empty;
    logic        full;
    logic [3:0]  level;
    logic        overflow;
`ifdef ADC_AVG_DROPCNT_EN
    logic [15:0] drop_count;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [11:0] exp_q [$];

    adc_avg_fifo #(.AVG_LOG2(2), .DEPTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .flush        (flush),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .empty        (empty),
        .full         (full),
        .level        (level),
        .overflow     (overflow)
`ifdef ADC_AVG_DROPCNT_EN
        ,
        .drop_count   (drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] v);
        sample_in    = v;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick();
    endtask

    task automatic send4(input logic [11:0] v, input bit pushed);
        if (pushed) exp_q.push_back(v);
        repeat (4) send(v);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    // Monitor: every accepted pop must present the oldest expected mean.
    always @(negedge clk) begin
        if (rd_en && !empty && !reset && !flush) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL pop_unexpected: got %0d expected none", rd_data);
            end else begin
                check("pop_data", {20'd0, rd_data}, {20'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        reset = 1'b0;
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_rd_data", rd_data, 0);

        // Basic mean with gaps between strobes
        exp_q.push_back(12'd250);
        send(12'd100);
        send(12'd200);
        send(12'd300);
        sample_in    = 12'd400;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        check("mean_empty", empty, 0);
        check("mean_level", level, 1);
        check("mean_rd_data", rd_data, 250);
        tick();
        pop();
        check("pop_empty", empty, 1);
        check("pop_level", level, 0);

        // Max value, then truncation (5 >> 2 = 1)
        send4(12'hFFF, 1);
        exp_q.push_back(12'd1);
        send(12'd1);
        send(12'd1);
        send(12'd1);
        send(12'd2);
        check("max_level", level, 2);
        check("max_rd_data", rd_data, 4095);
        pop();
        check("trunc_rd_data", rd_data, 1);
        pop();
        check("trunc_empty", empty, 1);

        // Fill to full with means 1..8
        for (int k = 1; k <= 7; k++) send4(12'(k), 1);
        check("lvl7_full", full, 0);
        send4(12'd8, 1);
        check("fill_full", full, 1);
        check("fill_level", level, 8);
        check("fill_overflow", overflow, 0);
        check("fill_rd_data", rd_data, 1);

        // Pop on the very edge a new mean completes while full
        send(12'd9);
        send(12'd9);
        send(12'd9);
        exp_q.push_back(12'd9);
        sample_in    = 12'd9;
        sample_valid = 1'b1;
        rd_en        = 1'b1;
        tick();
        sample_valid = 1'b0;
        rd_en        = 1'b0;
        check("simul_level", level, 8);
        check("simul_overflow", overflow, 0);
        check("simul_rd_data", rd_data, 2);
        tick();

        // Mean completing while full is dropped
        send4(12'd10, 0);
        check("drop_overflow", overflow, 1);
        check("drop_level", level, 8);
        check("drop_rd_data", rd_data, 2);
`ifdef ADC_AVG_DROPCNT_EN
        check("drop_count", drop_count, 1);
`endif
        repeat (8) pop();
        check("drain_empty", empty, 1);

        // Flush discards FIFO and partial sum, keeps overflow, ignores its sample
        send4(12'd7, 0);
        check("preflush_level", level, 1);
        send(12'd50);
        send(12'd50);
        flush        = 1'b1;
        sample_in    = 12'd4000;
        sample_valid = 1'b1;
        tick();
        flush        = 1'b0;
        sample_valid = 1'b0;
        check("flush_level", level, 0);
        check("flush_overflow", overflow, 1);
        check("flush_rd_hold", rd_data, 7);
        send4(12'd8, 1);
        check("flush_rd_data", rd_data, 8);
        check("flush_newlevel", level, 1);
        pop();

        // Reset mid-accumulation
        send(12'd50);
        send(12'd50);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_overflow", overflow, 0);
        check("rst2_rd_data", rd_data, 0);
        check("rst2_empty", empty, 1);
`ifdef ADC_AVG_DROPCNT_EN
        check("rst2_drop_count", drop_count, 0);
`endif
        send4(12'd8, 1);
        check("rst2_mean", rd_data, 8);
        pop();
        tick();
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
